ex_operand_stage: RTL and testbench

- ID/EX pipeline register that feeds the RV64 ALU.
- Accepts one decoded instruction per handshake and resolves rs1/rs2 through a forwarding network with EX/MEM and MEM/WB bypass.
- Applies operand-source muxing (rs1/PC/zero for A, rs2/imm for B) and presents registered dataA, dataB, ALUControl and word to the ALU.
- Handles back-pressure, flush and load-use hazard stall.

---
 rtl/ex_operand_stage.sv | 129 ++++++++++++
 tb/tb_ex_operand_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX operand register for the RV64 ALU: forwards rs1/rs2 from EX/MEM and MEM/WB,
// muxes operand sources, and handles back-pressure, flush and load-use stall.
module ex_operand_stage #(
  parameter int N          = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [N-1:0]          in_rs1_data,
  input  logic [N-1:0]          in_rs2_data,
  input  logic [N-1:0]          in_imm,
  input  logic [N-1:0]          in_pc,
  input  logic [1:0]            in_src_a,
  input  logic                  in_src_b,
  input  logic [3:0]            in_alu_ctrl,
  input  logic                  in_word,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic                  in_reg_write,
  input  logic [REG_ADDR_W-1:0] exm_rd_addr,
  input  logic                  exm_reg_write,
  input  logic                  exm_is_load,
  input  logic [N-1:0]          exm_data,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic                  wb_reg_write,
  input  logic [N-1:0]          wb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          dataA,
  output logic [N-1:0]          dataB,
  output logic [3:0]            ALUControl,
  output logic                  word,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic                  out_reg_write,
  output logic [N-1:0]          out_rs2_val,
  output logic                  hazard_stall
);

  logic [N-1:0]          rs1_fwd, rs2_fwd, a_sel;
  logic                  capture, snoop_a, snoop_b;
  logic [REG_ADDR_W-1:0] rs1_addr_reg, rs2_addr_reg;
  logic                  a_is_rs_reg, b_is_rs_reg;

  // EX/MEM beats MEM/WB; a load in EX/MEM has no data yet, so it never forwards.
  always_comb begin
    rs1_fwd = in_rs1_data;
    if (in_rs1_addr == '0)
      rs1_fwd = '0;
    else if (exm_reg_write && !exm_is_load && exm_rd_addr == in_rs1_addr)
      rs1_fwd = exm_data;
    else if (wb_reg_write && wb_rd_addr == in_rs1_addr)
      rs1_fwd = wb_data;
  end

  always_comb begin
    rs2_fwd = in_rs2_data;
    if (in_rs2_addr == '0)
      rs2_fwd = '0;
    else if (exm_reg_write && !exm_is_load && exm_rd_addr == in_rs2_addr)
      rs2_fwd = exm_data;
    else if (wb_reg_write && wb_rd_addr == in_rs2_addr)
      rs2_fwd = wb_data;
  end

  always_comb begin
    a_sel = rs1_fwd;
    case (in_src_a)
      2'b01:   a_sel = in_pc;
      2'b10:   a_sel = '0;
      default: a_sel = rs1_fwd;
    endcase
  end

  assign hazard_stall = in_valid && exm_reg_write && exm_is_load && (exm_rd_addr != '0) &&
                        (exm_rd_addr == in_rs1_addr || exm_rd_addr == in_rs2_addr);
  assign in_ready = (!out_valid || out_ready) && !hazard_stall;
  assign capture  = in_valid && in_ready;

  // A held instruction keeps watching writeback so its operands don't go stale.
  assign snoop_a = wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rs1_addr_reg);
  assign snoop_b = wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == rs2_addr_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      dataA         <= '0;
      dataB         <= '0;
      out_rs2_val   <= '0;
      ALUControl    <= '0;
      word          <= 1'b0;
      out_rd_addr   <= '0;
      out_reg_write <= 1'b0;
      rs1_addr_reg  <= '0;
      rs2_addr_reg  <= '0;
      a_is_rs_reg   <= 1'b0;
      b_is_rs_reg   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid     <= 1'b1;
      dataA         <= a_sel;
      dataB         <= in_src_b ? in_imm : rs2_fwd;
      out_rs2_val   <= rs2_fwd;
      ALUControl    <= in_alu_ctrl;
      word          <= in_word;
      out_rd_addr   <= in_rd_addr;
      out_reg_write <= in_reg_write;
      rs1_addr_reg  <= in_rs1_addr;
      rs2_addr_reg  <= in_rs2_addr;
      a_is_rs_reg   <= (in_src_a == 2'b00) || (in_src_a == 2'b11);
      b_is_rs_reg   <= !in_src_b;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      if (snoop_a && a_is_rs_reg)
        dataA <= wb_data;
      if (snoop_b) begin
        out_rs2_val <= wb_data;
        if (b_is_rs_reg)
          dataB <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed test-plan scenarios followed by random traffic,
// all checked every cycle against a record-based model of the held instruction.
module tb_ex_operand_stage;
  localparam int N = 64;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready;
  logic [RW-1:0] in_rs1_addr, in_rs2_addr, in_rd_addr, exm_rd_addr, wb_rd_addr;
  logic [N-1:0] in_rs1_data, in_rs2_data, in_imm, in_pc, exm_data, wb_data;
  logic [1:0] in_src_a;
  logic in_src_b, in_word, in_reg_write, exm_reg_write, exm_is_load, wb_reg_write;
  logic [3:0] in_alu_ctrl, ALUControl;
  logic flush, out_valid, out_ready, word, out_reg_write, hazard_stall;
  logic [N-1:0] dataA, dataB, out_rs2_val;
  logic [RW-1:0] out_rd_addr;

  ex_operand_stage #(.N(N), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_pc(in_pc), .in_src_a(in_src_a), .in_src_b(in_src_b),
    .in_alu_ctrl(in_alu_ctrl), .in_word(in_word), .in_rd_addr(in_rd_addr),
    .in_reg_write(in_reg_write), .exm_rd_addr(exm_rd_addr),
    .exm_reg_write(exm_reg_write), .exm_is_load(exm_is_load), .exm_data(exm_data),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .dataA(dataA), .dataB(dataB), .ALUControl(ALUControl), .word(word),
    .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write),
    .out_rs2_val(out_rs2_val), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  // The model holds the instruction itself (sources + resolved register values);
  // the operands the ALU sees are derived from that record when compared.
  typedef struct packed {
    logic          valid;
    logic [1:0]    src_a;
    logic          src_b;
    logic [N-1:0]  rs1v, rs2v, pc, imm;
    logic [RW-1:0] rs1a, rs2a, rd;
    logic [3:0]    ctrl;
    logic          wd, rw;
  } rec_t;

  rec_t m;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] fwd(input logic [RW-1:0] a, input logic [N-1:0] rf);
    if (a == 0) return '0;
    if (exm_reg_write && !exm_is_load && exm_rd_addr == a) return exm_data;
    if (wb_reg_write && wb_rd_addr == a) return wb_data;
    return rf;
  endfunction

  function automatic logic [N-1:0] op_a(input rec_t r);
    if (r.src_a == 2'b01) return r.pc;
    if (r.src_a == 2'b10) return '0;
    return r.rs1v;
  endfunction

  function automatic logic [N-1:0] op_b(input rec_t r);
    return r.src_b ? r.imm : r.rs2v;
  endfunction

  function automatic logic hazard_model();
    return in_valid && exm_reg_write && exm_is_load && exm_rd_addr != 0 &&
           (exm_rd_addr == in_rs1_addr || exm_rd_addr == in_rs2_addr);
  endfunction

  // One clock: check combinational outputs against the current inputs, advance the
  // model through the edge, then check the registered outputs.
  task automatic step();
    logic hz, rdy;
    rec_t nx;
    #1;
    hz  = hazard_model();
    rdy = (!m.valid || out_ready) && !hz;
    chk("hazard_stall", hazard_stall, N'(hz));
    chk("in_ready", in_ready, N'(rdy));
    nx = m;
    if (!rst_n) begin
      nx = '0;
    end else if (flush) begin
      nx.valid = 1'b0;
    end else if (in_valid && rdy) begin
      nx.valid = 1'b1;
      nx.src_a = in_src_a;  nx.src_b = in_src_b;
      nx.rs1v  = fwd(in_rs1_addr, in_rs1_data);
      nx.rs2v  = fwd(in_rs2_addr, in_rs2_data);
      nx.pc    = in_pc;     nx.imm = in_imm;
      nx.rs1a  = in_rs1_addr; nx.rs2a = in_rs2_addr;
      nx.rd    = in_rd_addr;  nx.ctrl = in_alu_ctrl;
      nx.wd    = in_word;     nx.rw   = in_reg_write;
    end else if (m.valid && out_ready) begin
      nx.valid = 1'b0;
    end else if (m.valid && wb_reg_write && wb_rd_addr != 0) begin
      if (wb_rd_addr == m.rs1a) nx.rs1v = wb_data;
      if (wb_rd_addr == m.rs2a) nx.rs2v = wb_data;
    end
    @(posedge clk);
    #1;
    m = nx;
    chk("out_valid", out_valid, N'(m.valid));
    if (m.valid) begin
      chk("dataA", dataA, op_a(m));
      chk("dataB", dataB, op_b(m));
      chk("out_rs2_val", out_rs2_val, m.rs2v);
      chk("ALUControl", N'(ALUControl), N'(m.ctrl));
      chk("word", N'(word), N'(m.wd));
      chk("out_rd_addr", N'(out_rd_addr), N'(m.rd));
      chk("out_reg_write", N'(out_reg_write), N'(m.rw));
    end
  endtask

  task automatic clear_inputs();
    in_valid = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_rs1_data = 0; in_rs2_data = 0;
    in_imm = 0; in_pc = 0; in_src_a = 0; in_src_b = 0; in_alu_ctrl = 0; in_word = 0;
    in_rd_addr = 0; in_reg_write = 0; exm_rd_addr = 0; exm_reg_write = 0;
    exm_is_load = 0; exm_data = 0; wb_rd_addr = 0; wb_reg_write = 0; wb_data = 0;
    flush = 0; out_ready = 1;
  endtask

  initial begin
    m = '0;
    clear_inputs();
    rst_n = 0;
    @(posedge clk);
    #1;

    // Reset held for two cycles with a valid instruction offered.
    in_valid = 1; in_rs1_addr = 5; in_rs1_data = 64'hAA; in_alu_ctrl = 4'hF;
    step(); step();
    chk("rst_out_valid", N'(out_valid), 0);
    chk("rst_dataA", dataA, 0);
    chk("rst_dataB", dataB, 0);
    chk("rst_rs2_val", out_rs2_val, 0);
    chk("rst_ctrl", N'(ALUControl), 0);
    chk("rst_word", N'(word), 0);
    chk("rst_rd", N'(out_rd_addr), 0);
    chk("rst_rw", N'(out_reg_write), 0);
    rst_n = 1;
    clear_inputs();
    #1;
    chk("rst_in_ready", N'(in_ready), 1);

    // Plain capture.
    in_valid = 1; in_rs1_addr = 5; in_rs1_data = 10; in_rs2_addr = 6; in_rs2_data = 3;
    in_alu_ctrl = 4'b1000; in_rd_addr = 4; in_reg_write = 1;
    step();
    chk("cap_valid", N'(out_valid), 1);
    chk("cap_dataA", dataA, 10);
    chk("cap_dataB", dataB, 3);
    chk("cap_ctrl", N'(ALUControl), 4'b1000);

    // Forwarding priority.
    in_rs1_addr = 7; in_rs1_data = 64'h11;
    exm_reg_write = 1; exm_rd_addr = 7; exm_data = 64'h55;
    wb_reg_write = 1;  wb_rd_addr = 7;  wb_data = 64'h99;
    step();
    chk("fwd_exm", dataA, 64'h55);
    exm_reg_write = 0;
    step();
    chk("fwd_wb", dataA, 64'h99);
    in_rs1_addr = 0;
    step();
    chk("fwd_x0", dataA, 0);

    // Load-use stall on rs2, then release.
    wb_reg_write = 0;
    in_rs1_addr = 1; in_rs2_addr = 8; in_rs2_data = 64'h1;
    exm_reg_write = 1; exm_is_load = 1; exm_rd_addr = 8; exm_data = 64'h77;
    #1;
    chk("lu_stall", N'(hazard_stall), 1);
    chk("lu_ready", N'(in_ready), 0);
    step();
    chk("lu_no_cap", N'(out_valid), 0);
    exm_is_load = 0;
    step();
    chk("lu_cap", N'(out_valid), 1);
    chk("lu_dataB", dataB, 64'h77);

    // Back-pressure with writeback snoop on a register-sourced B.
    exm_reg_write = 0;
    in_rs1_addr = 3; in_rs1_data = 64'h33; in_rs2_addr = 9; in_rs2_data = 64'h11;
    in_alu_ctrl = 4'b0010;
    step();
    out_ready = 0; wb_reg_write = 1; wb_rd_addr = 9; wb_data = 64'h1234;
    step();
    chk("snoop_dataB", dataB, 64'h1234);
    chk("snoop_rs2", out_rs2_val, 64'h1234);
    chk("snoop_dataA", dataA, 64'h33);
    wb_reg_write = 0;
    step(); step();
    chk("hold_dataB", dataB, 64'h1234);
    chk("hold_ctrl", N'(ALUControl), 4'b0010);

    // Immediate-sourced B must not be overwritten by the snoop.
    out_ready = 1; in_src_b = 1; in_imm = 64'h42;
    step();
    out_ready = 0; wb_reg_write = 1; wb_rd_addr = 9; wb_data = 64'h5555;
    step();
    chk("imm_dataB", dataB, 64'h42);
    chk("imm_rs2", out_rs2_val, 64'h5555);
    wb_reg_write = 0;

    // Flush with a concurrent accept, then a normal capture.
    out_ready = 1; flush = 1; in_src_b = 0; in_rs1_addr = 2; in_rs1_data = 64'hBEEF;
    step();
    chk("flush_valid", N'(out_valid), 0);
    flush = 0;
    step();
    chk("post_flush_valid", N'(out_valid), 1);
    chk("post_flush_dataA", dataA, 64'hBEEF);

    // Random traffic; small address range so forwarding and hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      rst_n         = ($urandom_range(0, 299) != 0);
      in_valid      = ($urandom_range(0, 3) != 0);
      in_rs1_addr   = RW'($urandom_range(0, 3));
      in_rs2_addr   = RW'($urandom_range(0, 3));
      in_rs1_data   = {$urandom, $urandom};
      in_rs2_data   = {$urandom, $urandom};
      in_imm        = {$urandom, $urandom};
      in_pc         = {$urandom, $urandom};
      in_src_a      = 2'($urandom_range(0, 3));
      in_src_b      = 1'($urandom_range(0, 1));
      in_alu_ctrl   = 4'($urandom_range(0, 15));
      in_word       = 1'($urandom_range(0, 1));
      in_rd_addr    = RW'($urandom_range(0, 31));
      in_reg_write  = 1'($urandom_range(0, 1));
      exm_rd_addr   = RW'($urandom_range(0, 3));
      exm_reg_write = 1'($urandom_range(0, 1));
      exm_is_load   = ($urandom_range(0, 3) == 0);
      exm_data      = {$urandom, $urandom};
      wb_rd_addr    = RW'($urandom_range(0, 3));
      wb_reg_write  = 1'($urandom_range(0, 1));
      wb_data       = {$urandom, $urandom};
      flush         = ($urandom_range(0, 15) == 0);
      out_ready     = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
